ifu_ibuf_ctl: RTL and testbench

IFU_IBUF_CTL -- requirements
Module: ifu_ibuf_ctl

---
 rtl/ifu_ibuf_ctl.sv | 126 ++++++++++++
 tb/tb_ifu_ibuf_ctl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_ibuf_ctl.sv
// rtl/ifu_ibuf_ctl.sv - 8-byte instruction fetch buffer with external length decode and registered issue
// Optional stall counter enabled by defining IFU_IBUF_PERF_EN.
module ifu_ibuf_ctl (
  input  logic        clk,
  input  logic        reset,
  input  logic        fill_vld,
  input  logic [31:0] fill_data,
  output logic        fill_rdy,
  output logic [7:0]  dec_opcode,
  output logic [4:0]  dec_valid,
  input  logic [5:0]  dec_len,
  output logic        instr_vld,
  output logic [2:0]  instr_len,
  output logic [39:0] instr_bytes,
  input  logic        instr_rdy,
  input  logic        flush,
  output logic [15:0] perf_stall_cnt
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t      state;
  logic [7:0]  mem [0:7];
  logic [2:0]  head;
  logic [2:0]  tail;
  logic [3:0]  occ;

  logic [2:0]  dec_k;
  logic        onehot;
  logic        decodable;
  logic        issue_en;
  logic        fill_en;
  logic [3:0]  occ_nxt;
  logic [39:0] issue_bytes;

  assign fill_rdy   = (state == ST_RUN) && (occ <= 4'd4);
  assign dec_opcode = (occ != 4'd0) ? mem[head] : 8'h00;
  assign dec_valid  = {occ > 4'd4, occ > 4'd3, occ > 4'd2, occ > 4'd1, occ > 4'd0};

  // Length decode: only a single set bit k (1..5) with k bytes present counts
  always_comb begin
    dec_k = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (dec_len[i]) dec_k = 3'(i);
    end
    onehot    = (dec_len != 6'd0) && ((dec_len & (dec_len - 6'd1)) == 6'd0);
    decodable = onehot && !dec_len[0] && ({1'b0, dec_k} <= occ);
  end

  // Flush squashes both the fill and the issue in the cycle it is seen
  assign issue_en = (state == ST_RUN) && !flush && decodable && (!instr_vld || instr_rdy);
  assign fill_en  = fill_vld && fill_rdy && !flush;

  // Gather head..head+k-1, zeroing bytes beyond the instruction length
  always_comb begin
    issue_bytes = '0;
    for (int j = 0; j < 5; j++) begin
      if (3'(j) < dec_k) issue_bytes[8*j +: 8] = mem[head + 3'(j)];
    end
  end

  // Occupancy after a possible fill and a possible issue in the same cycle
  always_comb begin
    occ_nxt = occ;
    if (fill_en)  occ_nxt = occ_nxt + 4'd4;
    if (issue_en) occ_nxt = occ_nxt - {1'b0, dec_k};
  end

  // Byte storage; contents are don't-care while unoccupied so no reset
  always_ff @(posedge clk) begin
    if (!reset && fill_en) begin
      for (int j = 0; j < 4; j++) begin
        mem[tail + 3'(j)] <= fill_data[8*j +: 8];
      end
    end
  end

  // Control FSM, pointers and registered instruction output
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      head        <= 3'd0;
      tail        <= 3'd0;
      occ         <= 4'd0;
      instr_vld   <= 1'b0;
      instr_len   <= 3'd0;
      instr_bytes <= 40'd0;
    end else if (flush) begin
      state     <= ST_FLUSH;
      head      <= 3'd0;
      tail      <= 3'd0;
      occ       <= 4'd0;
      instr_vld <= 1'b0;
    end else begin
      state <= ST_RUN;
      if (fill_en) tail <= tail + 3'd4;
      if (issue_en) begin
        head        <= head + dec_k;
        instr_vld   <= 1'b1;
        instr_len   <= dec_k;
        instr_bytes <= issue_bytes;
      end else if (instr_rdy) begin
        instr_vld <= 1'b0;
      end
      occ <= occ_nxt;
    end
  end

`ifdef IFU_IBUF_PERF_EN
  logic [15:0] stall_cnt;

  // Count cycles where bytes are waiting but the head cannot be decoded
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if ((state == ST_RUN) && (occ != 4'd0) && dec_len[0] && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ifu_ibuf_ctl.sv
// tb/tb_ifu_ibuf_ctl.sv - directed self-checking bench for ifu_ibuf_ctl
module tb_ifu_ibuf_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fill_vld;
  logic [31:0] fill_data;
  logic        fill_rdy;
  logic [7:0]  dec_opcode;
  logic [4:0]  dec_valid;
  logic [5:0]  dec_len;
  logic        instr_vld;
  logic [2:0]  instr_len;
  logic [39:0] instr_bytes;
  logic        instr_rdy;
  logic        flush;
  logic [15:0] perf_stall_cnt;

  logic [2:0]  len_of [0:255];
  logic [2:0]  dec_k_tb;
  logic        force_en;
  logic [5:0]  force_val;

  int n_chk;
  int n_fail;

  always #5 clk = ~clk;

  ifu_ibuf_ctl dut (
    .clk            (clk),
    .reset          (reset),
    .fill_vld       (fill_vld),
    .fill_data      (fill_data),
    .fill_rdy       (fill_rdy),
    .dec_opcode     (dec_opcode),
    .dec_valid      (dec_valid),
    .dec_len        (dec_len),
    .instr_vld      (instr_vld),
    .instr_len      (instr_len),
    .instr_bytes    (instr_bytes),
    .instr_rdy      (instr_rdy),
    .flush          (flush),
    .perf_stall_cnt (perf_stall_cnt)
  );

  // External length decoder model: table lookup on the head opcode
  always_comb begin
    dec_k_tb = len_of[dec_opcode];
    if (force_en)              dec_len = force_val;
    else if (dec_k_tb == 3'd0) dec_len = 6'b000001;
    else                       dec_len = 6'b000001 << dec_k_tb;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit chk_rst);
    reset     = 1'b1;
    fill_vld  = 1'b0;
    fill_data = 32'd0;
    flush     = 1'b0;
    instr_rdy = 1'b0;
    force_en  = 1'b0;
    force_val = 6'd0;
    step();
    step();
    if (chk_rst) begin
      @(negedge clk);
      check("rst_fill_rdy",  64'(fill_rdy),       64'd1);
      check("rst_dec_valid", 64'(dec_valid),      64'd0);
      check("rst_opcode",    64'(dec_opcode),     64'd0);
      check("rst_instr_vld", 64'(instr_vld),      64'd0);
      check("rst_instr_len", 64'(instr_len),      64'd0);
      check("rst_bytes",     64'(instr_bytes),    64'd0);
      check("rst_perf",      64'(perf_stall_cnt), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int   w;
    int   rcv;
    bit   hs;
    logic [7:0] b;

    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) len_of[i] = 3'd0;

    // Basic 1-byte issue: fill presented after edge N, written at N+1, issued at N+2
    do_reset(1'b1);
    len_of[8'h01] = 3'd1;
    len_of[8'h02] = 3'd1;
    fill_vld  = 1'b1;
    fill_data = 32'h04030201;
    step();
    fill_vld = 1'b0;
    @(negedge clk);
    check("t1_dec_valid_n1", 64'(dec_valid),  64'h0f);
    check("t1_opcode_n1",    64'(dec_opcode), 64'h01);
    check("t1_vld_n1",       64'(instr_vld),  64'd0);
    step();
    @(negedge clk);
    check("t1_vld_n2",       64'(instr_vld),   64'd1);
    check("t1_len",          64'(instr_len),   64'd1);
    check("t1_bytes",        64'(instr_bytes), 64'h01);
    check("t1_dec_valid_n2", 64'(dec_valid),   64'h07);
    check("t1_opcode_n2",    64'(dec_opcode),  64'h02);

    // 5-byte instruction across two fill words
    do_reset(1'b0);
    len_of[8'h01] = 3'd5;
    instr_rdy = 1'b1;
    fill_vld  = 1'b1;
    fill_data = 32'h04030201;
    step();
    fill_data = 32'h08070605;
    @(negedge clk);
    check("t2_dec_valid_a", 64'(dec_valid), 64'h0f);
    check("t2_rdy_a",       64'(fill_rdy),  64'd1);
    check("t2_short_vld",   64'(instr_vld), 64'd0);
    step();
    fill_vld = 1'b0;
    @(negedge clk);
    check("t2_rdy_full",    64'(fill_rdy),  64'd0);
    check("t2_dec_valid_b", 64'(dec_valid), 64'h1f);
    check("t2_vld_b",       64'(instr_vld), 64'd0);
    step();
    @(negedge clk);
    check("t2_vld",         64'(instr_vld),   64'd1);
    check("t2_len",         64'(instr_len),   64'd5);
    check("t2_bytes",       64'(instr_bytes), 64'h0504030201);
    check("t2_rdy_again",   64'(fill_rdy),    64'd1);
    check("t2_opcode",      64'(dec_opcode),  64'h06);
    check("t2_dec_valid_c", 64'(dec_valid),   64'h07);
    step();
    @(negedge clk);
    check("t2_vld_clear",   64'(instr_vld),   64'd0);

    // Multi-bit dec_len ignored, then back-pressure hold, then release
    do_reset(1'b0);
    len_of[8'h11] = 3'd2;
    len_of[8'h13] = 3'd1;
    fill_vld  = 1'b1;
    fill_data = 32'h14131211;
    force_en  = 1'b1;
    force_val = 6'b000110;
    step();
    fill_vld = 1'b0;
    step();
    @(negedge clk);
    check("t3_multibit_vld", 64'(instr_vld),  64'd0);
    check("t3_multibit_op",  64'(dec_opcode), 64'h11);
    check("t3_multibit_dv",  64'(dec_valid),  64'h0f);
    force_en = 1'b0;
    step();
    @(negedge clk);
    check("t3_vld",   64'(instr_vld),   64'd1);
    check("t3_len",   64'(instr_len),   64'd2);
    check("t3_bytes", 64'(instr_bytes), 64'h1211);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      check("t3_hold_vld",   64'(instr_vld),   64'd1);
      check("t3_hold_len",   64'(instr_len),   64'd2);
      check("t3_hold_bytes", 64'(instr_bytes), 64'h1211);
      check("t3_hold_op",    64'(dec_opcode),  64'h13);
      check("t3_hold_dv",    64'(dec_valid),   64'h03);
    end
    step();
    instr_rdy = 1'b1;
    step();
    @(negedge clk);
    check("t3_next_vld",   64'(instr_vld),   64'd1);
    check("t3_next_len",   64'(instr_len),   64'd1);
    check("t3_next_bytes", 64'(instr_bytes), 64'h13);
    check("t3_next_op",    64'(dec_opcode),  64'h14);
    check("t3_next_dv",    64'(dec_valid),   64'h01);
    step();
    @(negedge clk);
    check("t3_drop_vld",   64'(instr_vld),   64'd0);

    // Wrap-around: 5 fills, 1-byte issues, 20 bytes in order
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) len_of[8'h20 + i] = 3'd1;
    instr_rdy = 1'b1;
    w   = 0;
    rcv = 0;
    fill_vld  = 1'b1;
    fill_data = 32'h23222120;
    for (int cyc = 0; cyc < 100 && rcv < 20; cyc++) begin
      @(negedge clk);
      hs = fill_vld && fill_rdy;
      if (instr_vld) begin
        check("t4_byte", 64'(instr_bytes), 64'(8'h20 + 8'(rcv)));
        rcv++;
      end
      @(posedge clk);
      #1;
      if (hs) w++;
      b = 8'h20 + 8'(4 * w);
      fill_vld  = (w < 5);
      fill_data = {b + 8'd3, b + 8'd2, b + 8'd1, b};
    end
    check("t4_count", 64'(rcv), 64'd20);
    check("t4_fills", 64'(w),   64'd5);
    @(negedge clk);
    check("t4_end_vld", 64'(instr_vld), 64'd0);
    check("t4_end_dv",  64'(dec_valid), 64'd0);

    // Flush with concurrent fill and pending instruction
    do_reset(1'b0);
    len_of[8'h41] = 3'd1;
    len_of[8'h42] = 3'd1;
    fill_vld  = 1'b1;
    fill_data = 32'h44434241;
    step();
    fill_vld = 1'b0;
    step();
    @(negedge clk);
    check("t5_pre_vld", 64'(instr_vld), 64'd1);
    step();
    flush     = 1'b1;
    fill_vld  = 1'b1;
    fill_data = 32'h58575655;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t5_fl_vld", 64'(instr_vld),  64'd0);
    check("t5_fl_dv",  64'(dec_valid),  64'd0);
    check("t5_fl_op",  64'(dec_opcode), 64'd0);
    check("t5_fl_rdy", 64'(fill_rdy),   64'd0);
    step();
    @(negedge clk);
    check("t5_run_rdy", 64'(fill_rdy),  64'd1);
    check("t5_run_dv",  64'(dec_valid), 64'd0);
    step();
    fill_vld = 1'b0;
    @(negedge clk);
    check("t5_refill_dv", 64'(dec_valid),  64'h0f);
    check("t5_refill_op", 64'(dec_opcode), 64'h55);
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    @(negedge clk);
    check("t5_ext_rdy",  64'(fill_rdy), 64'd0);
    step();
    @(negedge clk);
    check("t5_ext_done", 64'(fill_rdy), 64'd1);

    // Head stall with 2 bytes occupied for 3 cycles
    do_reset(1'b0);
    len_of[8'h51] = 3'd2;
    instr_rdy = 1'b1;
    fill_vld  = 1'b1;
    fill_data = 32'h54535251;
    step();
    fill_vld = 1'b0;
    step();
    repeat (3) step();
    @(negedge clk);
    check("t6_dv",  64'(dec_valid), 64'h03);
    check("t6_vld", 64'(instr_vld), 64'd0);
`ifdef IFU_IBUF_PERF_EN
    check("t6_perf", 64'(perf_stall_cnt), 64'd3);
`else
    check("t6_perf", 64'(perf_stall_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
